// File: rtl/ram_program_loader_if.sv
// ---------------------------------------------------------------------------
// ram_program_loader_if
// Bundles the host-side and bus-side signals of the RAM program loader.
//   Host side   : prog_en (level request), byte_valid (async strobe), byte_in
//   Bus side    : bus_out/bus_oe (tri-state driver control), active-low
//                 n_load_addr / n_load_data / n_lr strobes
//   Status side : cpu_hold, addr, checksum, done, overrun
// Modports:
//   slave  - the loader itself (drives bus/status, receives host signals)
//   master - the host / top level (drives host signals, observes the rest)
// ---------------------------------------------------------------------------
interface ram_program_loader_if #(
    parameter int ADDR_W = 4
);
    logic              prog_en;
    logic              byte_valid;
    logic [7:0]        byte_in;
    logic [7:0]        bus_out;
    logic              bus_oe;
    logic              n_load_addr;
    logic              n_load_data;
    logic              n_lr;
    logic              cpu_hold;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        checksum;
    logic              done;
    logic              overrun;

    modport slave (
        input  prog_en, byte_valid, byte_in,
        output bus_out, bus_oe, n_load_addr, n_load_data, n_lr,
        output cpu_hold, addr, checksum, done, overrun
    );

    modport master (
        output prog_en, byte_valid, byte_in,
        input  bus_out, bus_oe, n_load_addr, n_load_data, n_lr,
        input  cpu_hold, addr, checksum, done, overrun
    );
endinterface

// File: rtl/ram_program_loader.sv
// ---------------------------------------------------------------------------
// ram_program_loader
// Fills the CPU's RAM from dedicated input pins before the CPU runs. Each
// host byte (one rising edge of the asynchronous byte_valid strobe) is
// replayed onto the shared bus as: MAR address load, input-register data
// load, RAM write -- the same order the control block uses. The CPU is held
// in reset while a programming session is in progress.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - ram_program_loader_if.slave: host inputs, bus driver + active-low
//          strobes (ANDed with the control block's strobes at the top level),
//          cpu_hold, next address, running checksum, done, sticky overrun
// DEPTH is expected to equal 2**ADDR_W so the address wraps to 0 after the
// last byte.
// ---------------------------------------------------------------------------
module ram_program_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    ram_program_loader_if.slave      bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic              sync1_r;
    logic              sync2_r;
    logic              sync3_r;
    logic              edge_s;

    logic [7:0]        byte_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        checksum_r;
    logic              done_r;
    logic              overrun_r;
    logic              last_s;
    logic              busy_s;

    logic [7:0]        bus_out_r;
    logic              bus_oe_r;
    logic              n_load_addr_r;
    logic              n_load_data_r;
    logic              n_lr_r;
    logic              cpu_hold_r;

    // One clean pulse per host strobe rising edge, after two metastability flops.
    assign edge_s = sync2_r & ~sync3_r;
    assign last_s = (addr_r == ADDR_W'(DEPTH - 1));
    // States in which a new edge cannot be accepted.
    assign busy_s = (state_r == ST_ADDR) || (state_r == ST_DATA) ||
                    (state_r == ST_WRITE) || (state_r == ST_NEXT);

    // Strobe synchroniser and edge-history flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= bus.byte_valid;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; dropping prog_en mid-session aborts straight to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.prog_en) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.prog_en) begin
                    state_nxt_s = ST_IDLE;
                end else if (edge_s) begin
                    state_nxt_s = ST_ADDR;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ADDR: begin
                if (!bus.prog_en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!bus.prog_en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!bus.prog_en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (!bus.prog_en) begin
                    state_nxt_s = ST_IDLE;
                end else if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (bus.prog_en) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bus and strobe outputs, registered from the next state so they change
    // exactly with the state and never glitch; an abort releases them at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_out_r     <= 8'h00;
            bus_oe_r      <= 1'b0;
            n_load_addr_r <= 1'b1;
            n_load_data_r <= 1'b1;
            n_lr_r        <= 1'b1;
            cpu_hold_r    <= 1'b0;
        end else begin
            n_load_addr_r <= (state_nxt_s != ST_ADDR);
            n_load_data_r <= (state_nxt_s != ST_DATA);
            n_lr_r        <= (state_nxt_s != ST_WRITE);
            bus_oe_r      <= (state_nxt_s == ST_ADDR) || (state_nxt_s == ST_DATA);
            cpu_hold_r    <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
            if (state_nxt_s == ST_ADDR) begin
                bus_out_r <= {{(8 - ADDR_W){1'b0}}, addr_r};
            end else if (state_nxt_s == ST_DATA) begin
                bus_out_r <= byte_r;
            end else begin
                bus_out_r <= 8'h00;
            end
        end
    end

    // Session datapath: byte capture, address/checksum progress, done and overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_r     <= 8'h00;
            addr_r     <= '0;
            checksum_r <= 8'h00;
            done_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && bus.prog_en) begin
                addr_r     <= '0;
                checksum_r <= 8'h00;
                done_r     <= 1'b0;
                overrun_r  <= 1'b0;
            end
            if ((state_r == ST_WAIT) && bus.prog_en && edge_s) begin
                byte_r <= bus.byte_in;
            end
            // Edges while busy are dropped; only the sticky flag records them.
            if (busy_s && edge_s) begin
                overrun_r <= 1'b1;
            end
            if ((state_r == ST_NEXT) && bus.prog_en) begin
                checksum_r <= checksum_r + byte_r;
                if (last_s) begin
                    addr_r <= '0;
                    done_r <= 1'b1;
                end else begin
                    addr_r <= addr_r + ADDR_W'(1);
                end
            end
        end
    end

    assign bus.bus_out     = bus_out_r;
    assign bus.bus_oe      = bus_oe_r;
    assign bus.n_load_addr = n_load_addr_r;
    assign bus.n_load_data = n_load_data_r;
    assign bus.n_lr        = n_lr_r;
    assign bus.cpu_hold    = cpu_hold_r;
    assign bus.addr        = addr_r;
    assign bus.checksum    = checksum_r;
    assign bus.done        = done_r;
    assign bus.overrun     = overrun_r;

endmodule
